mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch requester (IF) and the load/store requester (DM).
- Sits between pc/fetch logic, the load/store path and the memory macro.
- Arbitrates round-robin, sequences each access through issue/wait/respond, and returns read data to the winning requester.
- One access outstanding at a time.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (IF) and load/store (DM).
// Optional grant/conflict statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] if_rsp_data_o,
  input  logic                  dm_req_valid_i,
  output logic                  dm_req_ready_o,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic                  dm_wr_en_i,
  input  logic [3:0]            dm_byte_en_i,
  input  logic [DATA_WIDTH-1:0] dm_wr_data_i,
  output logic                  dm_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] dm_rsp_data_o,
  output logic                  mem_en_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wr_en_o,
  output logic [3:0]            mem_byte_en_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  busy_o,
  output logic [31:0]           if_grant_cnt_o,
  output logic [31:0]           dm_grant_cnt_o,
  output logic [31:0]           conflict_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_LAST = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  state_t                state_q, state_d;
  logic                  last_dm_q, last_dm_d;
  logic                  gnt_dm_q, gnt_dm_d;
  logic                  pick_dm;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [3:0]            be_q, be_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
  logic [DATA_WIDTH-1:0] dm_data_q, dm_data_d;
  logic [DATA_WIDTH-1:0] rsp_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_dm_q <= 1'b0;
      gnt_dm_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      be_q      <= 4'h0;
      cnt_q     <= 2'd0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_dm_q <= last_dm_d;
      gnt_dm_q  <= gnt_dm_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_dm_d      = last_dm_q;
    gnt_dm_d       = gnt_dm_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wr_d           = wr_q;
    be_d           = be_q;
    cnt_d          = cnt_q;
    if_data_d      = if_data_q;
    dm_data_d      = dm_data_q;
    pick_dm        = 1'b0;
    if_req_ready_o = 1'b0;
    dm_req_ready_o = 1'b0;
    mem_en_o       = 1'b0;
    if_rsp_valid_o = 1'b0;
    dm_rsp_valid_o = 1'b0;
    if_rsp_data_o  = if_data_q;
    dm_rsp_data_o  = dm_data_q;
    rsp_val        = wr_q ? '0 : mem_rd_data_i;
    case (state_q)
      IDLE: begin
        // rst gating keeps a handshake from completing on a reset edge
        if (!rst && (if_req_valid_i || dm_req_valid_i)) begin
          pick_dm   = dm_req_valid_i && (!if_req_valid_i || !last_dm_q);
          state_d   = ISSUE;
          last_dm_d = pick_dm;
          gnt_dm_d  = pick_dm;
          if (pick_dm) begin
            dm_req_ready_o = 1'b1;
            addr_d         = dm_addr_i;
            wr_d           = dm_wr_en_i;
            be_d           = dm_byte_en_i;
            wdata_d        = dm_wr_data_i;
          end else begin
            if_req_ready_o = 1'b1;
            addr_d         = if_addr_i;
            wr_d           = 1'b0;
            be_d           = 4'hF;
            wdata_d        = '0;
          end
        end
      end
      ISSUE: begin
        mem_en_o = !rst;
        cnt_d    = 2'd0;
        state_d  = (RD_LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = RESP;
        else                    cnt_d   = cnt_q + 2'd1;
      end
      RESP: begin
        state_d = IDLE;
        if (!rst) begin
          if (gnt_dm_q) begin
            dm_rsp_valid_o = 1'b1;
            dm_rsp_data_o  = rsp_val;
            dm_data_d      = rsp_val;
          end else begin
            if_rsp_valid_o = 1'b1;
            if_rsp_data_o  = rsp_val;
            if_data_d      = rsp_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o    = addr_q & ~DATA_WIDTH'(3);
  assign mem_wr_en_o   = wr_q && (state_q == ISSUE || state_q == WAIT);
  assign mem_byte_en_o = be_q;
  assign mem_wr_data_o = wdata_q;
  assign busy_o        = (state_q != IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_cnt_q, dm_cnt_q, cf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_cnt_q <= '0;
      dm_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      if (if_req_valid_i && if_req_ready_o && if_cnt_q != '1) if_cnt_q <= if_cnt_q + 32'd1;
      if (dm_req_valid_i && dm_req_ready_o && dm_cnt_q != '1) dm_cnt_q <= dm_cnt_q + 32'd1;
      if (state_q == IDLE && if_req_valid_i && dm_req_valid_i && cf_cnt_q != '1)
        cf_cnt_q <= cf_cnt_q + 32'd1;
    end
  end

  assign if_grant_cnt_o = if_cnt_q;
  assign dm_grant_cnt_o = dm_cnt_q;
  assign conflict_cnt_o = cf_cnt_q;
`else
  assign if_grant_cnt_o = '0;
  assign dm_grant_cnt_o = '0;
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=3.
module tb_mem_arbiter;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc;
  } mem_t;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  rsp_t rsp_q1[$];
  rsp_t rsp_q3[$];
  mem_t mq1[$];
  mem_t mq3[$];
  int   glog[$];

  // RD_LATENCY = 1 instance
  logic        if_v = 1'b0, if_rdy, if_rv;
  logic [31:0] if_a = '0, if_rd;
  logic        dm_v = 1'b0, dm_we = 1'b0, dm_rdy, dm_rv;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_a = '0, dm_wd = '0, dm_rd;
  logic        m_en, m_we, busy;
  logic [3:0]  m_be;
  logic [31:0] m_a, m_wd, m_rd, ifc, dmc, cfc;

  // RD_LATENCY = 3 instance (IF traffic only)
  logic        t3_if_v = 1'b0, t3_if_rdy, t3_if_rv;
  logic [31:0] t3_if_a = '0, t3_if_rd;
  logic        t3_dm_rdy, t3_dm_rv;
  logic [31:0] t3_dm_rd;
  logic        t3_m_en, t3_m_we, t3_busy;
  logic [3:0]  t3_m_be;
  logic [31:0] t3_m_a, t3_m_wd, t3_m_rd, t3_ifc, t3_dmc, t3_cfc;

  mem_arbiter #(.DATA_WIDTH(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst1),
    .if_req_valid_i(if_v), .if_req_ready_o(if_rdy), .if_addr_i(if_a),
    .if_rsp_valid_o(if_rv), .if_rsp_data_o(if_rd),
    .dm_req_valid_i(dm_v), .dm_req_ready_o(dm_rdy), .dm_addr_i(dm_a),
    .dm_wr_en_i(dm_we), .dm_byte_en_i(dm_be), .dm_wr_data_i(dm_wd),
    .dm_rsp_valid_o(dm_rv), .dm_rsp_data_o(dm_rd),
    .mem_en_o(m_en), .mem_addr_o(m_a), .mem_wr_en_o(m_we), .mem_byte_en_o(m_be),
    .mem_wr_data_o(m_wd), .mem_rd_data_i(m_rd), .busy_o(busy),
    .if_grant_cnt_o(ifc), .dm_grant_cnt_o(dmc), .conflict_cnt_o(cfc)
  );

  mem_arbiter #(.DATA_WIDTH(32), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst3),
    .if_req_valid_i(t3_if_v), .if_req_ready_o(t3_if_rdy), .if_addr_i(t3_if_a),
    .if_rsp_valid_o(t3_if_rv), .if_rsp_data_o(t3_if_rd),
    .dm_req_valid_i(1'b0), .dm_req_ready_o(t3_dm_rdy), .dm_addr_i(32'h0),
    .dm_wr_en_i(1'b0), .dm_byte_en_i(4'h0), .dm_wr_data_i(32'h0),
    .dm_rsp_valid_o(t3_dm_rv), .dm_rsp_data_o(t3_dm_rd),
    .mem_en_o(t3_m_en), .mem_addr_o(t3_m_a), .mem_wr_en_o(t3_m_we), .mem_byte_en_o(t3_m_be),
    .mem_wr_data_o(t3_m_wd), .mem_rd_data_i(t3_m_rd), .busy_o(t3_busy),
    .if_grant_cnt_o(t3_ifc), .dm_grant_cnt_o(t3_dmc), .conflict_cnt_o(t3_cfc)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: contents preloaded while the matching DUT is in reset
  logic [31:0] mem1[0:255];
  logic [31:0] mem3[0:255];
  logic [31:0] rd1 = '0, p3_0 = '0, p3_1 = '0, p3_2 = '0;
  assign m_rd    = rd1;
  assign t3_m_rd = p3_2;

  always @(posedge clk) begin
    if (rst1) begin
      mem1[1] <= 32'h1234_5678; mem1[4] <= 32'h0050_0093; mem1[8] <= 32'hCAFE_F00D;
      mem1[12] <= 32'h0BAD_C0DE; mem1[64] <= 32'h1122_3344;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem1[m_a[9:2]][8*b +: 8] <= m_wd[8*b +: 8];
      end else rd1 <= mem1[m_a[9:2]];
    end
  end

  always @(posedge clk) begin
    if (rst3) begin
      mem3[4] <= 32'h0050_0093; mem3[8] <= 32'hCAFE_F00D;
    end
    p3_0 <= (!rst3 && t3_m_en && !t3_m_we) ? mem3[t3_m_a[9:2]] : 32'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int dut, input int port, input logic v, input logic [31:0] a,
                       input logic we, input logic [3:0] be, input logic [31:0] wd);
    if (dut == 1 && port == 0) begin
      if_v = v; if_a = a;
    end else if (dut == 1) begin
      dm_v = v; dm_a = a; dm_we = we; dm_be = be; dm_wd = wd;
    end else begin
      t3_if_v = v; t3_if_a = a;
    end
  endtask

  task automatic req(input int dut, input int port, input logic [31:0] a, input logic we,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp,
                     input bit want_rsp);
    int   n;
    logic rdy;
    n = 0;
    @(negedge clk);
    drive(dut, port, 1'b1, a, we, be, wd);
    forever begin
      #1;
      rdy = (dut == 1) ? (port == 1 ? dm_rdy : if_rdy) : t3_if_rdy;
      if (rdy || n == 60) break;
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL req_timeout dut%0d port%0d: ready stayed 0, expected 1 within 60 cycles", dut, port);
    end else begin
      @(posedge clk);
      #1;
      if (dut == 1) begin
        mq1.push_back('{a & ~32'h3, we, be, wd, cyc});
        if (want_rsp) rsp_q1.push_back('{port, exp, cyc + 1});
        glog.push_back(port);
      end else begin
        mq3.push_back('{a & ~32'h3, 1'b0, 4'hF, 32'h0, cyc});
        if (want_rsp) rsp_q3.push_back('{port, exp, cyc + 3});
      end
    end
    drive(dut, port, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  // Monitors
  always @(negedge clk) begin
    rsp_t r;
    mem_t m;
    if (!rst1) begin
      if (if_rv || dm_rv) begin
        if (rsp_q1.size() == 0) begin
          chk("rsp1_unexpected", {30'h0, dm_rv, if_rv}, 32'h0);
        end else begin
          r = rsp_q1.pop_front();
          chk("rsp1_both", {31'h0, if_rv && dm_rv}, 32'h0);
          chk("rsp1_port", dm_rv ? 32'd1 : 32'd0, r.port);
          chk("rsp1_data", dm_rv ? dm_rd : if_rd, r.data);
          chk("rsp1_cyc", cyc, r.cyc);
        end
      end
      if (m_en) begin
        if (mq1.size() == 0) chk("mem1_unexpected", {31'h0, m_en}, 32'h0);
        else begin
          m = mq1.pop_front();
          chk("mem1_addr", m_a, m.addr);
          chk("mem1_we", {31'h0, m_we}, {31'h0, m.we});
          chk("mem1_be", {28'h0, m_be}, {28'h0, m.be});
          if (m.we) chk("mem1_wd", m_wd, m.wd);
          chk("mem1_cyc", cyc, m.cyc);
        end
      end
      if (busy) chk("rdy1_while_busy", {30'h0, if_rdy, dm_rdy}, 32'h0);
    end
  end

  always @(negedge clk) begin
    rsp_t r;
    mem_t m;
    if (!rst3) begin
      if (t3_if_rv || t3_dm_rv) begin
        if (rsp_q3.size() == 0) begin
          chk("rsp3_unexpected", {30'h0, t3_dm_rv, t3_if_rv}, 32'h0);
        end else begin
          r = rsp_q3.pop_front();
          chk("rsp3_port", t3_dm_rv ? 32'd1 : 32'd0, r.port);
          chk("rsp3_data", t3_dm_rv ? t3_dm_rd : t3_if_rd, r.data);
          chk("rsp3_cyc", cyc, r.cyc);
        end
      end
      if (t3_m_en) begin
        if (mq3.size() == 0) chk("mem3_unexpected", {31'h0, t3_m_en}, 32'h0);
        else begin
          m = mq3.pop_front();
          chk("mem3_addr", t3_m_a, m.addr);
          chk("mem3_we", {31'h0, t3_m_we}, 32'h0);
          chk("mem3_be", {28'h0, t3_m_be}, {28'h0, m.be});
          chk("mem3_cyc", cyc, m.cyc);
        end
      end
      if (t3_busy) chk("rdy3_while_busy", {30'h0, t3_if_rdy, t3_dm_rdy}, 32'h0);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q1.size() + rsp_q3.size() + mq1.size() + mq3.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", rsp_q1.size() + rsp_q3.size() + mq1.size() + mq3.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset1();
    @(negedge clk); rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst1 = 1'b0;
  endtask

  localparam logic [31:0] EXP_CF  = `ifdef MEM_ARB_STATS_EN 32'd4 `else 32'd0 `endif;
  localparam logic [31:0] EXP_IFG = `ifdef MEM_ARB_STATS_EN 32'd2 `else 32'd0 `endif;
  localparam logic [31:0] EXP_DMG = `ifdef MEM_ARB_STATS_EN 32'd3 `else 32'd0 `endif;
  localparam logic [31:0] EXP_T3G = `ifdef MEM_ARB_STATS_EN 32'd1 `else 32'd0 `endif;

  initial begin
    int exp_order[5] = '{1, 0, 1, 0, 1};
    repeat (2) @(posedge clk);
    @(negedge clk); rst1 = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_outputs_or", {31'h0, |{if_rdy, if_rv, if_rd, dm_rdy, dm_rv, dm_rd, m_en, m_a,
                                    m_we, m_be, m_wd, busy, ifc, dmc, cfc}}, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end

    // Directed accesses on the single-cycle-latency instance
    req(1, 0, 32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h0050_0093, 1'b1);
    req(1, 1, 32'h0000_0103, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1'b1);
    req(1, 1, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h1122_BEEF, 1'b1);
    req(1, 0, 32'h0000_0022, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1);
    drain();

    // Both requesters valid back-to-back after reset: DM wins the first tie
    reset1();
    glog.delete();
    fork
      begin
        req(1, 1, 32'h0000_0030, 1'b0, 4'hF, 32'h0, 32'h0BAD_C0DE, 1'b1);
        req(1, 1, 32'h0000_0044, 1'b1, 4'hF, 32'h0000_0055, 32'h0, 1'b1);
        req(1, 1, 32'h0000_0004, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b1);
      end
      begin
        req(1, 0, 32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h0050_0093, 1'b1);
        req(1, 0, 32'h0000_0020, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1);
      end
    join
    drain();
    chk("grant_count", glog.size(), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("grant_order", glog[i], exp_order[i]);
    chk("conflict_cnt", cfc, EXP_CF);
    chk("if_grant_cnt", ifc, EXP_IFG);
    chk("dm_grant_cnt", dmc, EXP_DMG);
    chk("if_rsp_hold", if_rd, 32'hCAFE_F00D);
    chk("dm_rsp_hold", dm_rd, 32'h1234_5678);

    // Three-cycle read latency, then a reset in WAIT
    req(3, 0, 32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h0050_0093, 1'b1);
    drain();
    req(3, 0, 32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    #1 chk("busy_in_wait", {31'h0, t3_busy}, 32'h1);
    @(negedge clk);
    rst3 = 1'b0;
    #1 chk("busy_after_rst", {31'h0, t3_busy}, 32'h0);
    t3_if_v = 1'b1; t3_if_a = 32'h0000_0020;
    #1 chk("ready_after_rst", {31'h0, t3_if_rdy}, 32'h1);
    t3_if_v = 1'b0;
    req(3, 0, 32'h0000_0020, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1);
    drain();
    chk("t3_if_grant_cnt", t3_ifc, EXP_T3G);
    chk("t3_conflict_cnt", t3_cfc, 32'h0);
    chk("t3_dm_grant_cnt", t3_dmc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
